event_frame_buffer: RTL and testbench
=====================================

Name: event_frame_buffer

Overview:
- Parametrised successor to the 1-bit event image RAM: stores one PIX_W-bit value per pixel of an IMWIDTH x IMHEIGHT sensor frame.
- Accepts DVS-style (x,y) events through a valid/ready port and updates the stored pixel by read-modify-write. MODE selects binary set or saturating count.
- A separate registered read port serves the downstream median filter. A built-in sweep FSM clears the whole frame between integration windows.

Parameters:
- IMWIDTH, 240, frame width in pixels.
- IMHEIGHT, 180, frame height in pixels.
- COORD_W, 8, width of the x and y coordinates.
- PIX_W, 4, bits stored per pixel.
- MODE, 1, 0 = binary (event writes 1), 1 = saturating event count.
- ADDR_W, 16, memory address width; must be at least clog2(IMWIDTH*IMHEIGHT).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event this cycle.
- ev_x  in  COORD_W  event column.
- ev_y  in  COORD_W  event row.
- rd_req  in  1  read request.
- rd_x  in  COORD_W  read column.
- rd_y  in  COORD_W  read row.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  PIX_W  pixel value.
- clear_start  in  1  request a full-frame clear.
- clear_busy  out  1  a clear is in progress (DRAIN or CLEAR state).
- clear_done  out  1  one-cycle pulse when the sweep finishes.
- drop_cnt  out  16  number of out-of-range events, saturating.

Behaviour:
- Reset values: ev_ready=1, rd_valid=0, rd_data=0, clear_busy=0, clear_done=0, drop_cnt=0. FSM goes to IDLE and the pipeline valids clear. Memory contents are NOT reset; they are undefined until the first clear.
- Address = y*IMWIDTH + x. An event or read is in range iff x<IMWIDTH and y<IMHEIGHT.
- Event acceptance: an event is accepted when ev_valid && ev_ready on the clock edge. ev_ready = (state==IDLE), independent of ev_valid. In IDLE one event per cycle can be accepted.
- Event pipeline:
  - S0 (accept cycle): range check and address computation. An out-of-range event is dropped and drop_cnt increments, saturating at 0xFFFF.
  - S1: in-range address registered; synchronous RAM read issued.
  - S2: old value available; the write happens on the edge ending S2.
  - New value: MODE 0 gives 1. MODE 1 gives old+1, saturating at 2^PIX_W-1.
- Hazard forwarding:
  - Memory is read-before-write.
  - Keep a last-write register (addr, data, valid). If the S2 address equals the address written on the preceding edge, use the last-write data instead of the RAM output.
  - Back-to-back events to the same pixel must therefore count every event. No stall is allowed.
- Read port:
  - rd_req at edge t gives rd_valid=1 with rd_data during cycle t+1 (1-cycle latency, fully pipelined).
  - Out-of-range read: rd_valid=1, rd_data=0.
  - Reads while clear_busy=1: rd_valid=1, rd_data=0.
  - A read and an event write to the same pixel in the same cycle return the pre-write value.
- Clear FSM, states IDLE -> DRAIN -> CLEAR -> IDLE:
  - IDLE: clear_start=1 moves to DRAIN and zeroes drop_cnt. If ev_valid is also high that cycle, the event is still accepted (ev_ready was 1).
  - DRAIN: wait until S1 and S2 are empty (at most 2 cycles), then go to CLEAR.
  - CLEAR: write 0 to address 0..IMWIDTH*IMHEIGHT-1, one per cycle. After the last address, return to IDLE and pulse clear_done for that one cycle.
  - clear_start outside IDLE is ignored.
  - A full clear takes IMWIDTH*IMHEIGHT plus at most 3 cycles.
- Reset mid-clear: FSM returns to IDLE and the sweep address resets. Memory is left partially cleared.

Decomposition:
- Shared package event_fb_pkg holds:
  - the FSM state encoding (IDLE, DRAIN, CLEAR);
  - the MODE_BINARY / MODE_COUNT constants;
  - a function for the address width of IMWIDTH*IMHEIGHT.
- One sub-module, event_fb_ram: simple dual-read single-write synchronous RAM with read-before-write. It has one write port, one internal RMW read port and one external read port, and is inferred as block RAM (two copies are acceptable).
- The FSM, pipeline, forwarding and range checks stay in the top level.

Test Plan:
- Reset, then clear_start pulse: clear_busy stays high and clear_done pulses after at most 43203 cycles. Reads of (0,0), (239,179) and (120,90) return 0 with rd_valid one cycle after rd_req.
- MODE=1: 20 consecutive events to (5,7) with no gaps: reading (5,7) returns 15 (saturated) and (6,7) returns 0.
- MODE=1: alternating events (3,3),(4,3),(3,3),(4,3): reads return 2 and 2, which checks forwarding with non-adjacent repeats.
- MODE=0: three events to (10,10): read returns 1.
- Events at (240,0) and (0,180): drop_cnt=2 and no pixel changes. A read of (240,0) returns rd_valid=1, rd_data=0. Then a clear_start resets drop_cnt to 0.
- clear_start asserted in the same cycle as an event to (1,1): the event is accepted and then cleared, and ev_ready stays 0 throughout. Asserting rst 100 cycles into the sweep sets clear_busy=0 and ev_ready=1 on the following cycle.

Source files
------------

// File: rtl/event_fb_pkg.sv
// Shared definitions for the event frame buffer: clear-FSM encoding, pixel
// update modes and an address-width helper.
package event_fb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam int MODE_BINARY = 0;
  localparam int MODE_COUNT  = 1;

  // Number of address bits needed to index n words (at least 1).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_fb_ram.sv
// Frame store: one write port and two registered read ports (RMW and external),
// read-before-write on every port.
module event_fb_ram
  import event_fb_pkg::*;
#(
  parameter int DEPTH  = 43200,
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PIX_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [PIX_W-1:0]  o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [PIX_W-1:0]  o_rdata_b
);

  localparam int MEM_AW = addr_width(DEPTH);

  logic [PIX_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; non-blocking
  // assignments make both reads see the value from before this edge's write.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr[MEM_AW-1:0]] <= i_wdata;
    o_rdata_a <= r_mem[i_raddr_a[MEM_AW-1:0]];
    o_rdata_b <= r_mem[i_raddr_b[MEM_AW-1:0]];
  end

endmodule

// File: rtl/event_frame_buffer.sv
// Per-pixel event accumulator: 3-stage read-modify-write event pipeline with
// one-deep write forwarding, a registered read port and a full-frame clear FSM.
module event_frame_buffer
  import event_fb_pkg::*;
#(
  parameter int IMWIDTH  = 240,
  parameter int IMHEIGHT = 180,
  parameter int COORD_W  = 8,
  parameter int PIX_W    = 4,
  parameter int MODE     = MODE_COUNT,
  parameter int ADDR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [COORD_W-1:0] ev_x,
  input  logic [COORD_W-1:0] ev_y,
  input  logic               rd_req,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_valid,
  output logic [PIX_W-1:0]   rd_data,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [15:0]        drop_cnt
);

  localparam int                DEPTH     = IMWIDTH * IMHEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = '1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_sweep;
  logic              r_clear_done;
  logic [15:0]       r_drop_cnt;
  logic              r_s1_valid, r_s2_valid, r_lw_valid;
  logic [ADDR_W-1:0] r_s1_addr, r_s2_addr, r_lw_addr;
  logic [PIX_W-1:0]  r_lw_data;
  logic              r_rd_valid, r_rd_zero;

  logic              w_ev_fire, w_ev_in_range, w_rd_in_range;
  logic [ADDR_W-1:0] w_ev_addr, w_rd_addr;
  logic [PIX_W-1:0]  w_rmw_q, w_ext_q, w_old, w_new;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [PIX_W-1:0]  w_wdata;

  assign ev_ready   = (r_state == ST_IDLE);
  assign clear_busy = (r_state == ST_DRAIN) || (r_state == ST_CLEAR);
  assign clear_done = r_clear_done;
  assign drop_cnt   = r_drop_cnt;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = (r_rd_valid && !r_rd_zero) ? w_ext_q : '0;
  assign w_ev_fire  = ev_valid && ev_ready;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    w_ev_in_range = (int'(ev_x) < IMWIDTH) && (int'(ev_y) < IMHEIGHT);
    w_rd_in_range = (int'(rd_x) < IMWIDTH) && (int'(rd_y) < IMHEIGHT);
    w_ev_addr     = ADDR_W'(ev_y) * ADDR_W'(IMWIDTH) + ADDR_W'(ev_x);
    w_rd_addr     = '0;
    if (w_rd_in_range) w_rd_addr = ADDR_W'(rd_y) * ADDR_W'(IMWIDTH) + ADDR_W'(rd_x);

    // The RAM read in S1 misses only the write made on the edge just before S2.
    w_old = (r_lw_valid && (r_lw_addr == r_s2_addr)) ? r_lw_data : w_rmw_q;
    if (MODE == MODE_BINARY) w_new = PIX_W'(1);
    else                     w_new = (w_old == PIX_MAX) ? w_old : w_old + PIX_W'(1);

    w_we    = r_s2_valid;
    w_waddr = r_s2_addr;
    w_wdata = w_new;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_sweep;
      w_wdata = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sweep      <= '0;
      r_clear_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE:  if (clear_start) r_state <= ST_DRAIN;
        // Nothing enters S1 outside IDLE, so once S1 is empty the S2 write lands on this edge.
        ST_DRAIN: if (!r_s1_valid) begin
          r_state <= ST_CLEAR;
          r_sweep <= '0;
        end
        ST_CLEAR: if (r_sweep == LAST_ADDR) begin
          r_state      <= ST_IDLE;
          r_clear_done <= 1'b1;
        end else begin
          r_sweep <= r_sweep + ADDR_W'(1);
        end
        default:  r_state <= ST_IDLE;
      endcase

      if ((r_state == ST_IDLE) && clear_start)
        r_drop_cnt <= '0;
      else if (w_ev_fire && !w_ev_in_range && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_lw_valid <= 1'b0;
      r_lw_addr  <= '0;
      r_lw_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_s1_valid <= w_ev_fire && w_ev_in_range;
      r_s1_addr  <= w_ev_addr;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_lw_valid <= r_s2_valid;
      r_lw_addr  <= r_s2_addr;
      r_lw_data  <= w_new;
      r_rd_valid <= rd_req;
      r_rd_zero  <= !w_rd_in_range || clear_busy;
    end
  end

  event_fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_s1_addr),
    .o_rdata_a (w_rmw_q),
    .i_raddr_b (w_rd_addr),
    .o_rdata_b (w_ext_q)
  );

endmodule

// File: tb/tb_event_frame_buffer.sv
// Directed bench for event_frame_buffer: a counting and a binary instance
// share stimulus; each step compares outputs against hand-computed values.
module tb_event_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0;
  logic [7:0] ev_x = '0, ev_y = '0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_x = '0, rd_y = '0;
  logic       clear_start = 1'b0;

  logic        c_ev_ready, c_rd_valid, c_clear_busy, c_clear_done;
  logic [3:0]  c_rd_data;
  logic [15:0] c_drop_cnt;
  logic        b_ev_ready, b_rd_valid, b_clear_busy, b_clear_done;
  logic [3:0]  b_rd_data;
  logic [15:0] b_drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  event_frame_buffer #(.MODE(1)) u_cnt (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(c_ev_ready), .ev_x(ev_x), .ev_y(ev_y),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(c_rd_valid), .rd_data(c_rd_data),
    .clear_start(clear_start), .clear_busy(c_clear_busy), .clear_done(c_clear_done),
    .drop_cnt(c_drop_cnt)
  );

  event_frame_buffer #(.MODE(0)) u_bin (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(b_ev_ready), .ev_x(ev_x), .ev_y(ev_y),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .clear_start(clear_start), .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .drop_cnt(b_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_px(input int x, input int y);
    rd_req = 1'b1;
    rd_x   = 8'(x);
    rd_y   = 8'(y);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic send_ev(input int x, input int y);
    ev_valid = 1'b1;
    ev_x     = 8'(x);
    ev_y     = 8'(y);
    tick();
    ev_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  leak;

    // Reset state
    tick(); tick();
    check("rst_ev_ready",   c_ev_ready,   1);
    check("rst_rd_valid",   c_rd_valid,   0);
    check("rst_rd_data",    c_rd_data,    0);
    check("rst_clear_busy", c_clear_busy, 0);
    check("rst_clear_done", c_clear_done, 0);
    check("rst_drop_cnt",   c_drop_cnt,   0);
    rst = 1'b0;
    tick();

    // Clear requested together with an event to (1,1)
    check("pre_clr_ev_ready", c_ev_ready, 1);
    clear_start = 1'b1;
    ev_valid = 1'b1; ev_x = 8'd1; ev_y = 8'd1;
    tick();
    clear_start = 1'b0;
    ev_valid = 1'b0;
    n = 1; seen = 0; leak = 0;
    while (!seen && n <= 43210) begin
      if (c_clear_done) seen = 1;
      else begin
        if (c_ev_ready || !c_clear_busy) leak = 1;
        tick();
        n++;
      end
    end
    check("clr_done_seen",   seen, 1);
    check("clr_cycles_ok",   (n <= 43203), 1);
    check("clr_busy_noready", leak, 0);
    check("clr_done_bin",    b_clear_done, 1);
    tick();
    check("clr_done_pulse",  c_clear_done, 0);
    check("clr_ready_back",  c_ev_ready, 1);

    // Cleared pixels, read latency
    check("rd_valid_idle", c_rd_valid, 0);
    read_px(0, 0);
    check("rd_valid_lat", c_rd_valid, 1);
    check("rd_0_0", c_rd_data, 0);
    read_px(239, 179);
    check("rd_239_179", c_rd_data, 0);
    read_px(120, 90);
    check("rd_120_90", c_rd_data, 0);
    read_px(1, 1);
    check("rd_1_1_cnt", c_rd_data, 0);
    check("rd_1_1_bin", b_rd_data, 0);
    tick();
    check("rd_valid_drop", c_rd_valid, 0);

    // 20 back-to-back events to (5,7)
    ev_valid = 1'b1; ev_x = 8'd5; ev_y = 8'd7;
    repeat (20) tick();
    ev_valid = 1'b0;
    repeat (3) tick();
    read_px(5, 7);
    check("sat_5_7_cnt", c_rd_data, 15);
    check("sat_5_7_bin", b_rd_data, 1);
    read_px(6, 7);
    check("nb_6_7", c_rd_data, 0);

    // Alternating (3,3),(4,3),(3,3),(4,3)
    ev_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_x = (i % 2 == 0) ? 8'd3 : 8'd4;
      ev_y = 8'd3;
      tick();
    end
    ev_valid = 1'b0;
    repeat (3) tick();
    read_px(3, 3);
    check("alt_3_3", c_rd_data, 2);
    read_px(4, 3);
    check("alt_4_3", c_rd_data, 2);

    // Three events to (10,10)
    ev_valid = 1'b1; ev_x = 8'd10; ev_y = 8'd10;
    repeat (3) tick();
    ev_valid = 1'b0;
    repeat (3) tick();
    read_px(10, 10);
    check("bin_10_10", b_rd_data, 1);
    check("cnt_10_10", c_rd_data, 3);

    // Read in the same cycle as the event write returns the old value
    send_ev(20, 20);
    tick();
    read_px(20, 20);
    check("rw_same_old", c_rd_data, 0);
    read_px(20, 20);
    check("rw_same_new", c_rd_data, 1);

    // Out-of-range events
    send_ev(240, 0);
    send_ev(0, 180);
    repeat (3) tick();
    check("drop_cnt_cnt", c_drop_cnt, 2);
    check("drop_cnt_bin", b_drop_cnt, 2);
    read_px(240, 0);
    check("oor_rd_valid", c_rd_valid, 1);
    check("oor_rd_data",  c_rd_data,  0);
    read_px(0, 1);
    check("oor_alias_0_1", c_rd_data, 0);
    read_px(0, 0);
    check("oor_0_0", c_rd_data, 0);

    // Clear start zeroes drop_cnt; reads during the clear return 0
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr2_drop_zero", c_drop_cnt, 0);
    check("clr2_busy",      c_clear_busy, 1);
    check("clr2_not_ready", c_ev_ready, 0);
    read_px(5, 7);
    check("busy_rd_valid", c_rd_valid, 1);
    check("busy_rd_data",  c_rd_data,  0);
    repeat (98) tick();

    // Reset about 100 cycles into the sweep
    rst = 1'b1;
    tick();
    check("mid_rst_busy",  c_clear_busy, 0);
    check("mid_rst_ready", c_ev_ready, 1);
    check("mid_rst_done",  c_clear_done, 0);
    rst = 1'b0;
    tick();
    read_px(5, 7);
    check("partial_5_7_cnt", c_rd_data, 15);
    check("partial_5_7_bin", b_rd_data, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
